// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round controller: countdown, pseudo-random mole presentation,
// press scoring against the current mole, and period speedup after runs of hits.
module mole_round_sequencer #(
  parameter int          PERIOD_W        = 27,
  parameter int          START_PERIOD    = 100_000_000,
  parameter int          MIN_PERIOD      = 25_000_000,
  parameter int          PERIOD_STEP     = 5_000_000,
  parameter int          SPEEDUP_HITS    = 4,
  parameter int          ROUND_MOLES     = 30,
  parameter int          COUNTDOWN_TICKS = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] button_i,
  output logic [1:0]  game_state_o,
  output logic [3:0]  mole_location_o,
  output logic        mole_tick_o,
  output logic        whacked_o,
  output logic [7:0]  score_o,
  output logic [7:0]  miss_o,
  output logic [7:0]  moles_left_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_COUNTDOWN = 2'b01,
    S_PLAY      = 2'b10,
    S_OVER      = 2'b11
  } state_t;

  localparam logic [PERIOD_W-1:0] START_P  = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] STEP_P   = PERIOD_W'(PERIOD_STEP);
  localparam logic [PERIOD_W:0]   FLOOR_P  = (PERIOD_W+1)'(MIN_PERIOD + PERIOD_STEP);
  localparam logic [7:0]          ROUND_N  = 8'(ROUND_MOLES);
  localparam logic [7:0]          CD_LAST  = 8'(COUNTDOWN_TICKS - 1);
  localparam logic [7:0]          HIT_LAST = 8'(SPEEDUP_HITS - 1);

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_lfsr;
  logic [PERIOD_W-1:0] r_period;    // period requested for the next mole
  logic [PERIOD_W-1:0] r_cur_p;     // period of the mole currently running
  logic [PERIOD_W-1:0] r_div;
  logic [7:0]          r_cd_cnt;
  logic [7:0]          r_hit_cnt;
  logic                r_hit_flag;
  logic [3:0]          r_loc;
  logic                r_tick;
  logic                r_whacked;
  logic [7:0]          r_score;
  logic [7:0]          r_miss;
  logic [7:0]          r_moles_left;

  logic                w_running, w_period_end, w_start, w_cd_done, w_present;
  logic                w_press, w_hit, w_miss, w_speedup;
  logic [15:0]         w_target;
  logic [3:0]          w_new_loc;
  logic [PERIOD_W-1:0] w_faster, w_period_nxt;
  logic                w_lfsr_fb;

  assign w_running    = (r_state == S_COUNTDOWN) || (r_state == S_PLAY);
  assign w_period_end = w_running && (r_div == r_cur_p - PERIOD_W'(1));
  assign w_start      = start_i && ((r_state == S_IDLE) || (r_state == S_OVER));
  assign w_cd_done    = (r_state == S_COUNTDOWN) && w_period_end && (r_cd_cnt == CD_LAST);
  assign w_present    = w_cd_done ||
                        ((r_state == S_PLAY) && w_period_end && (r_moles_left != 8'd0));

  // Presses are judged against the outgoing location even on a period-end cycle.
  assign w_target  = 16'd1 << r_loc;
  assign w_press   = (r_state == S_PLAY) && (button_i != 16'd0);
  assign w_hit     = w_press && (button_i == w_target) && !r_hit_flag;
  assign w_miss    = w_press && (button_i != w_target);
  assign w_speedup = w_hit && (r_hit_cnt == HIT_LAST);

  assign w_faster     = ({1'b0, r_period} >= FLOOR_P) ? (r_period - STEP_P) : MIN_P;
  assign w_period_nxt = w_start ? START_P : (w_speedup ? w_faster : r_period);

  assign w_new_loc = (r_lfsr[3:0] == r_loc) ? (r_lfsr[3:0] + 4'd1) : r_lfsr[3:0];
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // NOTE: every sequential register uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (w_start) w_state_nxt = S_COUNTDOWN;
      S_COUNTDOWN: if (w_cd_done) w_state_nxt = S_PLAY;
      S_PLAY:      if (w_period_end && (r_moles_left == 8'd0)) w_state_nxt = S_OVER;
      S_OVER:      if (w_start) w_state_nxt = S_COUNTDOWN;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_lfsr       <= LFSR_SEED;
      r_period     <= START_P;
      r_cur_p      <= START_P;
      r_div        <= '0;
      r_cd_cnt     <= '0;
      r_hit_cnt    <= '0;
      r_hit_flag   <= 1'b0;
      r_loc        <= '0;
      r_tick       <= 1'b0;
      r_whacked    <= 1'b0;
      r_score      <= '0;
      r_miss       <= '0;
      r_moles_left <= '0;
    end else begin
      r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
      r_period  <= w_period_nxt;
      r_tick    <= w_present;
      r_whacked <= w_hit;

      if (w_start) begin
        r_div        <= '0;
        r_cur_p      <= START_P;
        r_cd_cnt     <= '0;
        r_hit_cnt    <= '0;
        r_hit_flag   <= 1'b0;
        r_score      <= '0;
        r_miss       <= '0;
        r_moles_left <= ROUND_N;
      end else begin
        // A shorter period only applies from the next wrap; the running count is never cut.
        if (w_period_end) begin
          r_div   <= '0;
          r_cur_p <= w_period_nxt;
        end else if (w_running) begin
          r_div <= r_div + PERIOD_W'(1);
        end

        if ((r_state == S_COUNTDOWN) && w_period_end) r_cd_cnt <= r_cd_cnt + 8'd1;

        if (w_speedup)  r_hit_cnt <= '0;
        else if (w_hit) r_hit_cnt <= r_hit_cnt + 8'd1;

        if (w_hit && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
        if (w_miss && (r_miss != 8'hFF)) r_miss  <= r_miss + 8'd1;

        if (w_present) begin
          r_loc        <= w_new_loc;
          r_moles_left <= r_moles_left - 8'd1;
          r_hit_flag   <= 1'b0;
        end else if (w_hit) begin
          r_hit_flag <= 1'b1;
        end
      end
    end
  end

  assign game_state_o    = r_state;
  assign mole_location_o = r_loc;
  assign mole_tick_o     = r_tick;
  assign whacked_o       = r_whacked;
  assign score_o         = r_score;
  assign miss_o          = r_miss;
  assign moles_left_o    = r_moles_left;

endmodule
